// File: rtl/adain_pkg.sv
// Shared constants and types for the AdaIN lane collector.
// Lane count, index width, collector state encoding.
package adain_pkg;

    localparam int LANES = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    function automatic logic [IDX_W:0] group_count(
        input logic [IDX_W-1:0] idx
    );
        return {1'b0, idx} + (IDX_W+1)'(1);
    endfunction

endpackage

// File: rtl/demux_lane_dec.sv
// Lane write-enable decoder for the AdaIN lane collector.
// Turns the current lane index into a one-hot write strobe.
module demux_lane_dec
    import adain_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [LANES-1:0] wen
);

    // One-hot strobe for the lane being written; all-zero when idle.
    always_comb begin
        wen = '0;
        if (en) begin
            wen[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_1to8_collect.sv
// Serial-to-8-lane collector: word k of a group lands in lane k.
// Optional DEMUX_LAST_EN adds in_last / out_count for short groups.
module demux_1to8_collect
    import adain_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DEMUX_LAST_EN
    input  logic             in_last,
    output logic [3:0]       out_count,
`endif
    output logic [WIDTH-1:0] out_lane0,
    output logic [WIDTH-1:0] out_lane1,
    output logic [WIDTH-1:0] out_lane2,
    output logic [WIDTH-1:0] out_lane3,
    output logic [WIDTH-1:0] out_lane4,
    output logic [WIDTH-1:0] out_lane5,
    output logic [WIDTH-1:0] out_lane6,
    output logic [WIDTH-1:0] out_lane7
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] lane [LANES];
    logic [LANES-1:0] wen;
    logic             accept;
    logic             last;
    logic             close;

`ifdef DEMUX_LAST_EN
    assign last = in_last;
`else
    assign last = 1'b0;
`endif

    assign out_valid = (state == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign close     = accept && ((idx == IDX_W'(LANES-1)) || last);

    demux_lane_dec u_dec (
        .idx (idx),
        .en  (accept),
        .wen (wen)
    );

    // Group state and write index; a consumed group restarts at lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            idx   <= '0;
        end else if (close) begin
            state <= HOLD;
            idx   <= '0;
        end else if (accept) begin
            state <= COLLECT;
            idx   <= idx + IDX_W'(1);
        end else if (out_valid && out_ready) begin
            state <= COLLECT;
            idx   <= '0;
        end
    end

    // Lane registers: write the indexed lane, zero the tail on an early close.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                lane[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wen[i]) begin
                    lane[i] <= in_data;
                end else if (accept && last && (IDX_W'(i) > idx)) begin
                    lane[i] <= '0;
                end
            end
        end
    end

`ifdef DEMUX_LAST_EN
    // Number of real words in the group, captured when it closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (close) begin
            out_count <= group_count(idx);
        end
    end
`endif

    assign out_lane0 = lane[0];
    assign out_lane1 = lane[1];
    assign out_lane2 = lane[2];
    assign out_lane3 = lane[3];
    assign out_lane4 = lane[4];
    assign out_lane5 = lane[5];
    assign out_lane6 = lane[6];
    assign out_lane7 = lane[7];

endmodule

// File: tb/tb_demux_1to8_collect.sv
// Directed bench for demux_1to8_collect.
// Table-driven first group, then hand-written multi-cycle sequences.
module tb_demux_1to8_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        in_last;
`ifdef DEMUX_LAST_EN
    logic [3:0]  out_count;
`endif
    logic [15:0] l0, l1, l2, l3, l4, l5, l6, l7;
    logic [7:0][15:0] lanes_w;

    int tests = 0;
    int fails = 0;

    assign lanes_w = {l7, l6, l5, l4, l3, l2, l1, l0};

    always #5 clk = ~clk;

    demux_1to8_collect #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_LAST_EN
        .in_last   (in_last),
        .out_count (out_count),
`endif
        .out_lane0 (l0),
        .out_lane1 (l1),
        .out_lane2 (l2),
        .out_lane3 (l3),
        .out_lane4 (l4),
        .out_lane5 (l5),
        .out_lane6 (l6),
        .out_lane7 (l7)
    );

    typedef struct {
        logic             v;
        logic [15:0]      d;
        logic             r;
        logic             exp_ir;
        logic             exp_ov;
        bit               chk;
        logic [7:0][15:0] lanes;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [7:0][15:0] seq(input logic [15:0] base);
        logic [7:0][15:0] r;
        for (int i = 0; i < 8; i++) r[i] = base + 16'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_lanes(input string name,
                             input logic [7:0][15:0] exp);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s lane%0d", name, i),
                  32'(lanes_w[i]), 32'(exp[i]));
    endtask

    // Drive one cycle at the falling edge, check in_ready, step past rise.
    task automatic cyc(input logic v, input logic [15:0] d, input logic r,
                       input logic l, input logic exp_ir, input string name);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        in_last   = l;
        #1;
        check({name, " in_ready"}, 32'(in_ready), 32'(exp_ir));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0][15:0] exp;

        for (int k = 0; k < 9; k++) begin
            tbl[k].v      = (k < 8);
            tbl[k].d      = (k < 8) ? 16'(k + 1) : 16'hDEAD;
            tbl[k].r      = 1'b1;
            tbl[k].exp_ir = 1'b1;
            tbl[k].exp_ov = (k == 7);
            tbl[k].chk    = (k == 7);
            tbl[k].lanes  = seq(16'h0001);
        end

        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; in_last = 1'b0;

        // reset state
        do_reset();
        #1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst in_ready", 32'(in_ready), 1);
        chk_lanes("rst", '0);

        // T1: table-driven single group 1..8
        for (int k = 0; k < 9; k++) begin
            cyc(tbl[k].v, tbl[k].d, tbl[k].r, 1'b0, tbl[k].exp_ir,
                $sformatf("t1[%0d]", k));
            check($sformatf("t1[%0d] out_valid", k), 32'(out_valid),
                  32'(tbl[k].exp_ov));
            if (tbl[k].chk) chk_lanes($sformatf("t1[%0d]", k), tbl[k].lanes);
        end

        // T2: 16 back-to-back words, two groups, no stall
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 16'h0010 + 16'(k), 1'b1, 1'b0, 1'b1, "t2");
            check($sformatf("t2[%0d] out_valid", k), 32'(out_valid),
                  32'(k == 7 || k == 15));
            if (k == 7) chk_lanes("t2 g0", seq(16'h0010));
            if (k == 8) check("t2 lane0 reuse", 32'(l0), 32'h18);
            if (k == 15) chk_lanes("t2 g1", seq(16'h0018));
        end

        // T3: back-pressure holds group, release accepts next word
        do_reset();
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 16'h0030 + 16'(k), 1'b0, 1'b0, 1'b1, "t3 fill");
        check("t3 out_valid", 32'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 16'h00EE, 1'b0, 1'b0, 1'b0, "t3 stall");
            check("t3 stall out_valid", 32'(out_valid), 1);
            chk_lanes("t3 stall", seq(16'h0030));
        end
        cyc(1'b1, 16'h0040, 1'b1, 1'b0, 1'b1, "t3 release");
        check("t3 release out_valid", 32'(out_valid), 0);
        exp = seq(16'h0030);
        exp[0] = 16'h0040;
        chk_lanes("t3 release", exp);
        for (int k = 1; k < 8; k++)
            cyc(1'b1, 16'h0040 + 16'(k), 1'b1, 1'b0, 1'b1, "t3 next");
        check("t3 next out_valid", 32'(out_valid), 1);
        chk_lanes("t3 next", seq(16'h0040));

        // T4: reset mid-group discards partial words
        do_reset();
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 16'h0050 + 16'(k), 1'b1, 1'b0, 1'b1, "t4 part");
        check("t4 part lane2", 32'(l2), 32'h52);
        do_reset();
        #1;
        check("t4 rst out_valid", 32'(out_valid), 0);
        chk_lanes("t4 rst", '0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 16'h00A0 + 16'(k), 1'b1, 1'b0, 1'b1, "t4");
            check($sformatf("t4[%0d] out_valid", k), 32'(out_valid),
                  32'(k == 7));
        end
        chk_lanes("t4", seq(16'h00A0));

        // T5: in_valid every other cycle; idle data ignored
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0)
                cyc(1'b1, 16'h00B0 + 16'(k / 2), 1'b1, 1'b0, 1'b1, "t5");
            else
                cyc(1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b1, "t5 idle");
            check($sformatf("t5[%0d] out_valid", k), 32'(out_valid),
                  32'(k == 14));
            if (k == 14) chk_lanes("t5", seq(16'h00B0));
        end

`ifdef DEMUX_LAST_EN
        // T6: early close zeroes the tail, reports count
        cyc(1'b1, 16'h0011, 1'b1, 1'b0, 1'b1, "t6");
        cyc(1'b1, 16'h0022, 1'b1, 1'b0, 1'b1, "t6");
        check("t6 pre out_valid", 32'(out_valid), 0);
        cyc(1'b1, 16'h0033, 1'b1, 1'b1, 1'b1, "t6 last");
        check("t6 out_valid", 32'(out_valid), 1);
        check("t6 out_count", 32'(out_count), 3);
        exp = '0;
        exp[0] = 16'h0011; exp[1] = 16'h0022; exp[2] = 16'h0033;
        chk_lanes("t6", exp);
        // T7: last on the 8th word is a normal group, starts from HOLD
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 16'h0060 + 16'(k), 1'b1, (k == 7), 1'b1, "t7");
        check("t7 out_valid", 32'(out_valid), 1);
        check("t7 out_count", 32'(out_count), 8);
        chk_lanes("t7", seq(16'h0060));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
